// File: rtl/move_tx_framer.sv
// rtl/move_tx_framer.sv - wraps a game move into a 4-byte frame (sync, header, move, checksum) for UART tx
// Optional one-entry pending move buffer is enabled by defining MOVE_TX_FRAMER_QUEUE_EN.
module move_tx_framer #(
  parameter int         BYTE_GAP  = 74_481,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       move_valid_in,
  input  logic [7:0] move_in,
  input  logic       color_in,
  output logic       tx_trigger_out,
  output logic [7:0] tx_byte_out,
  output logic       busy_out,
  output logic       frame_done_out,
  output logic       drop_out,
  output logic [6:0] seq_out
);

  // The SEND cycle is the first cycle of each byte slot, so GAP lasts BYTE_GAP-1 cycles.
  localparam int CNT_W = (BYTE_GAP > 2) ? $clog2(BYTE_GAP - 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(BYTE_GAP - 2);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       seq_q;
  logic [7:0]       move_q, hdr_q, byte_q, byte_d;
  logic             load_frame, chain;
  logic [7:0]       new_move;
  logic             new_color;
  logic [6:0]       new_seq;

  assign busy_out       = (state_q != IDLE);
  assign tx_trigger_out = (state_q == SEND);
  assign frame_done_out = (state_q == GAP) && (cnt_q == '0) && (idx_q == 2'd3);
  assign tx_byte_out    = byte_q;
  assign seq_out        = seq_q;

  // A chained frame is loaded in the frame_done cycle, before seq_q has advanced.
  assign new_seq = (state_q == IDLE) ? seq_q : seq_q + 7'd1;

`ifdef MOVE_TX_FRAMER_QUEUE_EN
  logic       pend_full_q;
  logic [7:0] pend_move_q;
  logic       pend_color_q;

  assign drop_out  = move_valid_in && busy_out && pend_full_q;
  assign chain     = frame_done_out && (pend_full_q || move_valid_in);
  assign new_move  = pend_full_q ? pend_move_q  : move_in;
  assign new_color = pend_full_q ? pend_color_q : color_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pend_full_q  <= 1'b0;
      pend_move_q  <= 8'h00;
      pend_color_q <= 1'b0;
    end else if (chain) begin
      pend_full_q <= 1'b0;
    end else if (move_valid_in && busy_out && !pend_full_q) begin
      pend_full_q  <= 1'b1;
      pend_move_q  <= move_in;
      pend_color_q <= color_in;
    end
  end
`else
  assign drop_out  = move_valid_in && busy_out;
  assign chain     = 1'b0;
  assign new_move  = move_in;
  assign new_color = color_in;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    load_frame = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (move_valid_in) begin
          state_d    = SEND;
          idx_d      = 2'd0;
          load_frame = 1'b1;
        end
      end
      SEND: begin
        state_d = GAP;
        cnt_d   = GAP_LOAD;
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q != 2'd3) begin
          state_d = SEND;
          idx_d   = idx_q + 2'd1;
        end else if (chain) begin
          state_d    = SEND;
          idx_d      = 2'd0;
          load_frame = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_d = SYNC_BYTE;
    unique case (idx_d)
      2'd0: byte_d = SYNC_BYTE;
      2'd1: byte_d = hdr_q;
      2'd2: byte_d = move_q;
      2'd3: byte_d = SYNC_BYTE ^ hdr_q ^ move_q;
      default: byte_d = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      seq_q   <= 7'd0;
      move_q  <= 8'h00;
      hdr_q   <= 8'h00;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (frame_done_out)
        seq_q <= seq_q + 7'd1;
      if (load_frame) begin
        move_q <= new_move;
        hdr_q  <= {new_color, new_seq};
      end
      // Byte register only changes on entry to SEND, so it holds until the next trigger.
      if (state_d == SEND)
        byte_q <= byte_d;
    end
  end

endmodule
